// File: rtl/npu_conv_pkg.sv
// Shared conv-path definitions: sequencer state encoding, legal kernel sizes
// and the slice-buffer geometry that w_slice and its controller must agree on.
package npu_conv_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DECIDE  = 4'd1,
    S_FILL    = 4'd2,
    S_SETTLE  = 4'd3,
    S_READ    = 4'd4,
    S_WAIT_V  = 4'd5,
    S_ISSUE   = 4'd6,
    S_WAIT_PE = 4'd7,
    S_CLEAR   = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  localparam logic [2:0] KERNEL_3 = 3'd3;
  localparam logic [2:0] KERNEL_6 = 3'd6;

  localparam int ROWS_DEF     = 10;
  localparam int TILES_K6_DEF = 4;

  function automatic logic kernel_legal(input logic [2:0] k);
    return (k == KERNEL_3) || (k == KERNEL_6);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Loadable down-counter; o_expired is the terminal-count flag (count == 0).
module wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/w_slice_ctrl.sv
// Weight slice buffer sequencer: fill tracking, per-tile weight read, PE handoff,
// buffer delete after each filter group. All outputs are registered.
//
// state     | meaning
// IDLE      | waiting for conv_en, counters and err cleared
// DECIDE    | pick tiles per group from latched kernel, reject bad setups
// FILL      | counting im2col row beats up to ROWS
// SETTLE    | one cycle for the slice buffer to arm
// READ      | weight_read pulse for current tile
// WAIT_V    | waiting for weight_valid, bounded by the read timer
// ISSUE     | waiting for pe_ready, then pe_start
// WAIT_PE   | waiting for pe_done
// CLEAR     | buffer delete pulse, next group or finish
// DONE      | done pulse on entry, held until conv_en drops
module w_slice_ctrl
  import npu_conv_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int TILES_K6 = TILES_K6_DEF,
  parameter int GROUP_W  = 8,
  parameter int TIMEOUT  = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sudo_reset,
  input  logic               conv_en,
  input  logic [2:0]         kernel,
  input  logic [GROUP_W-1:0] group_total,
  input  logic               we_im2col_valid,
  output logic               weight_read,
  input  logic               weight_valid,
  input  logic               pe_ready,
  output logic               pe_start,
  input  logic               pe_done,
  output logic               we_valid_del,
  output logic [2:0]         tile_idx,
  output logic [GROUP_W-1:0] group_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int FILL_W = $clog2(ROWS + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(ROWS);
  localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(ROWS - 1);
  localparam logic [2:0]        TILES_K6_V = 3'(TILES_K6);
  // Timer runs through WAIT_V only, so DONE lands TIMEOUT cycles after the read pulse.
  localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(TIMEOUT - 2);

  state_t r_state, w_next;

  logic [FILL_W-1:0]  r_fill_cnt;
  logic [2:0]         r_tile_idx, r_tiles, r_kernel;
  logic [GROUP_W-1:0] r_group_idx, r_group_total;
  logic               r_err, r_weight_read, r_pe_start, r_del, r_busy, r_done;

  logic w_fill_full, w_last_tile, w_last_group, w_expired;
  logic w_weight_read, w_pe_start, w_del, w_busy, w_done;

  assign w_fill_full  = (r_fill_cnt == FILL_FULL) ||
                        (we_im2col_valid && (r_fill_cnt == FILL_LAST));
  assign w_last_tile  = (r_tile_idx == r_tiles - 3'd1);
  assign w_last_group = (r_group_idx == r_group_total - GROUP_W'(1));

  wait_timer #(.W(TMR_W)) u_wait_timer (
    .clk        (clk),
    .rst_n      (reset),
    .i_clr      (sudo_reset),
    .i_load     (r_state == S_READ),
    .i_load_val (TMR_LOAD),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_state <= S_IDLE;
    else if (sudo_reset) r_state <= S_IDLE;
    else                 r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (conv_en) w_next = S_DECIDE;
      S_DECIDE:  w_next = (!kernel_legal(r_kernel) || r_group_total == '0) ? S_DONE : S_FILL;
      S_FILL:    if (w_fill_full) w_next = S_SETTLE;
      S_SETTLE:  w_next = S_READ;
      S_READ:    w_next = S_WAIT_V;
      S_WAIT_V:  if (weight_valid) w_next = S_ISSUE;
                 else if (w_expired) w_next = S_DONE;
      S_ISSUE:   if (pe_ready) w_next = S_WAIT_PE;
      S_WAIT_PE: if (pe_done) w_next = w_last_tile ? S_CLEAR : S_READ;
      S_CLEAR:   w_next = w_last_group ? S_DONE : S_FILL;
      S_DONE:    if (!conv_en) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (!conv_en && r_state != S_IDLE && r_state != S_DONE) w_next = S_IDLE;
  end

  // Outputs are decoded from the next state so every pulse lines up with its state.
  always_comb begin
    w_weight_read = (w_next == S_READ);
    w_pe_start    = (r_state == S_ISSUE) && (w_next == S_WAIT_PE);
    w_del         = (w_next == S_CLEAR);
    w_done        = (w_next == S_DONE) && (r_state != S_DONE);
    w_busy        = (w_next != S_IDLE) && (w_next != S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill_cnt <= '0; r_tile_idx <= '0; r_tiles <= '0; r_kernel <= '0;
      r_group_idx <= '0; r_group_total <= '0; r_err <= 1'b0;
      r_weight_read <= 1'b0; r_pe_start <= 1'b0; r_del <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0;
    end else if (sudo_reset) begin
      r_fill_cnt <= '0; r_tile_idx <= '0; r_tiles <= '0; r_kernel <= '0;
      r_group_idx <= '0; r_group_total <= '0; r_err <= 1'b0;
      r_weight_read <= 1'b0; r_pe_start <= 1'b0; r_del <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0;
    end else begin
      r_weight_read <= w_weight_read;
      r_pe_start    <= w_pe_start;
      r_del         <= w_del;
      r_busy        <= w_busy;
      r_done        <= w_done;
      case (r_state)
        S_IDLE: begin
          r_err <= 1'b0; r_tile_idx <= '0; r_group_idx <= '0; r_fill_cnt <= '0;
          if (conv_en) begin
            r_kernel      <= kernel;
            r_group_total <= group_total;
          end
        end
        S_DECIDE: begin
          r_tiles <= (r_kernel == KERNEL_6) ? TILES_K6_V : 3'd1;
          if (!kernel_legal(r_kernel) && w_next == S_DONE) r_err <= 1'b1;
        end
        S_FILL:
          if (we_im2col_valid && r_fill_cnt != FILL_FULL) r_fill_cnt <= r_fill_cnt + FILL_W'(1);
        S_WAIT_V:
          if (w_next == S_DONE) r_err <= 1'b1;
        S_WAIT_PE:
          if (w_next == S_READ) r_tile_idx <= r_tile_idx + 3'd1;
        S_CLEAR: begin
          r_fill_cnt <= '0;
          r_tile_idx <= '0;
          if (w_next == S_FILL) r_group_idx <= r_group_idx + GROUP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign weight_read  = r_weight_read;
  assign pe_start     = r_pe_start;
  assign we_valid_del = r_del;
  assign tile_idx     = r_tile_idx;
  assign group_idx    = r_group_idx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_w_slice_ctrl.sv
// Scoreboard bench for w_slice_ctrl: stimulus queues expected pulse events,
// a negedge monitor pops and compares each pulse the DUT presents.
module tb_w_slice_ctrl;

  localparam int TIMEOUT = 200;
  localparam int K_READ = 0, K_START = 1, K_DEL = 2, K_DONE = 3;

  logic       clk = 1'b0;
  logic       reset, sudo_reset, conv_en, we_im2col_valid;
  logic [2:0] kernel;
  logic [7:0] group_total;
  logic       weight_read, weight_valid, pe_ready, pe_start, pe_done;
  logic       we_valid_del, busy, done, err;
  logic [2:0] tile_idx;
  logic [7:0] group_idx;

  w_slice_ctrl dut (
    .clk(clk), .reset(reset), .sudo_reset(sudo_reset), .conv_en(conv_en),
    .kernel(kernel), .group_total(group_total), .we_im2col_valid(we_im2col_valid),
    .weight_read(weight_read), .weight_valid(weight_valid), .pe_ready(pe_ready),
    .pe_start(pe_start), .pe_done(pe_done), .we_valid_del(we_valid_del),
    .tile_idx(tile_idx), .group_idx(group_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   kind;
    int   tile;
    int   group;
    logic err;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, errors = 0;
  int  cnt[4];
  int  cyc = 0, read_cyc = 0, done_cyc = 0, beat_cyc = 0, en_cyc = 0;
  bit  wv_en = 1'b1;

  function automatic string kname(input int k);
    case (k)
      K_READ:  return "weight_read";
      K_START: return "pe_start";
      K_DEL:   return "we_valid_del";
      default: return "done";
    endcase
  endfunction

  task automatic push(input int k, input int t, input int g, input logic e);
    ev_t ev;
    ev.kind = k; ev.tile = t; ev.group = g; ev.err = e;
    exp_q.push_back(ev);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic observe(input int k);
    ev_t ev;
    cnt[k]++;
    if (k == K_READ) read_cyc = cyc;
    if (k == K_DONE) done_cyc = cyc;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s tile %0d group %0d err %0d (cycle %0d)",
               kname(k), tile_idx, group_idx, err, cyc);
    end else begin
      ev = exp_q.pop_front();
      if (ev.kind != k || ev.tile != int'(tile_idx) || ev.group != int'(group_idx) || ev.err != err) begin
        errors++;
        $display("FAIL event got %s t%0d g%0d e%0d expected %s t%0d g%0d e%0d (cycle %0d)",
                 kname(k), tile_idx, group_idx, err, kname(ev.kind), ev.tile, ev.group, ev.err, cyc);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every pulse output is matched against the expected-event queue.
  initial forever begin
    @(negedge clk);
    if (reset === 1'b1) begin
      if (weight_read)  observe(K_READ);
      if (pe_start)     observe(K_START);
      if (we_valid_del) observe(K_DEL);
      if (done)         observe(K_DONE);
    end
  end

  // Slice buffer answers a read one cycle later; PE finishes 3 cycles after start.
  initial begin
    bit pend;
    int pcnt;
    pend = 1'b0; pcnt = 0;
    weight_valid = 1'b0; pe_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      weight_valid = pend && wv_en;
      pend = weight_read;
      pe_done = (pcnt == 1);
      if (pcnt > 0) pcnt--;
      if (pe_start) pcnt = 3;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  task automatic wait_count(input string name, input int k, input int target, input int budget);
    int i;
    i = 0;
    while (cnt[k] < target && i < budget) begin
      cyc1();
      i++;
    end
    checks++;
    if (cnt[k] < target) begin
      errors++;
      $display("FAIL %s timeout: %s count %0d required %0d", name, kname(k), cnt[k], target);
    end
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      we_im2col_valid = 1'b1;
      beat_cyc = cyc;
      cyc1();
    end
    we_im2col_valid = 1'b0;
  endtask

  task automatic start_conv(input logic [2:0] k, input logic [7:0] g);
    kernel = k;
    group_total = g;
    conv_en = 1'b1;
    en_cyc = cyc;
    cyc1();
    cyc1();
  endtask

  task automatic stop_conv(input string name);
    conv_en = 1'b0;
    repeat (3) cyc1();
    chk({name, "_busy_idle"}, int'(busy), 0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic push_k6_group(input int g);
    for (int t = 0; t < 4; t++) begin
      push(K_READ, t, g, 1'b0);
      push(K_START, t, g, 1'b0);
    end
    push(K_DEL, 3, g, 1'b0);
  endtask

  initial begin
    reset = 1'b0; sudo_reset = 1'b0; conv_en = 1'b0; kernel = 3'd0;
    group_total = 8'd0; we_im2col_valid = 1'b0; pe_ready = 1'b1;
    clear_cnt();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_outputs", int'({weight_read, pe_start, we_valid_del, tile_idx, group_idx, busy, done, err}), 0);
    cyc1();

    // 1: kernel 3, two groups
    clear_cnt();
    for (int g = 0; g < 2; g++) begin
      push(K_READ, 0, g, 1'b0);
      push(K_START, 0, g, 1'b0);
      push(K_DEL, 0, g, 1'b0);
    end
    push(K_DONE, 0, 1, 1'b0);
    start_conv(3'd3, 8'd2);
    send_beats(10);
    wait_count("t1_read0", K_READ, 1, 20);
    chk("t1_latency_g0", read_cyc - beat_cyc, 2);
    wait_count("t1_del0", K_DEL, 1, 50);
    send_beats(10);
    wait_count("t1_read1", K_READ, 2, 20);
    chk("t1_latency_g1", read_cyc - beat_cyc, 2);
    wait_count("t1_done", K_DONE, 1, 50);
    chk("t1_starts", cnt[K_START], 2);
    chk("t1_dels", cnt[K_DEL], 2);
    stop_conv("t1");

    // 2: kernel 6, one group, four tiles
    clear_cnt();
    push_k6_group(0);
    push(K_DONE, 0, 0, 1'b0);
    start_conv(3'd6, 8'd1);
    send_beats(10);
    wait_count("t2_done", K_DONE, 1, 200);
    chk("t2_reads", cnt[K_READ], 4);
    chk("t2_starts", cnt[K_START], 4);
    stop_conv("t2");

    // 3: illegal kernel
    clear_cnt();
    push(K_DONE, 0, 0, 1'b1);
    kernel = 3'd5; group_total = 8'd1; conv_en = 1'b1; en_cyc = cyc;
    wait_count("t3_done", K_DONE, 1, 5);
    chk("t3_done_within_2", int'(done_cyc - en_cyc <= 2), 1);
    chk("t3_err_set", int'(err), 1);
    conv_en = 1'b0;
    repeat (3) cyc1();
    chk("t3_err_cleared", int'(err), 0);
    chk("t3_no_reads", cnt[K_READ], 0);

    // 4: read timeout
    clear_cnt();
    wv_en = 1'b0;
    push(K_READ, 0, 0, 1'b0);
    push(K_DONE, 0, 0, 1'b1);
    start_conv(3'd3, 8'd1);
    send_beats(10);
    wait_count("t4_done", K_DONE, 1, TIMEOUT + 50);
    chk("t4_timeout_cycles", done_cyc - read_cyc, TIMEOUT);
    chk("t4_err", int'(err), 1);
    stop_conv("t4");
    wv_en = 1'b1;

    // 5: abort in WAIT_PE, then restart from an empty buffer
    clear_cnt();
    push(K_READ, 0, 0, 1'b0);
    push(K_START, 0, 0, 1'b0);
    start_conv(3'd6, 8'd1);
    send_beats(10);
    wait_count("t5_start", K_START, 1, 30);
    conv_en = 1'b0;
    cyc1();
    chk("t5_busy_after_abort", int'(busy), 0);
    repeat (8) cyc1();
    chk("t5_no_del", cnt[K_DEL], 0);
    chk("t5_no_done", cnt[K_DONE], 0);
    clear_cnt();
    push_k6_group(0);
    push(K_DONE, 0, 0, 1'b0);
    start_conv(3'd6, 8'd1);
    send_beats(9);
    repeat (4) cyc1();
    chk("t5_no_read_9_beats", cnt[K_READ], 0);
    send_beats(1);
    wait_count("t5_read", K_READ, 1, 20);
    chk("t5_latency", read_cyc - beat_cyc, 2);
    wait_count("t5_done", K_DONE, 1, 200);
    stop_conv("t5");

    // 6: partial fill, stray beats, soft reset mid-FILL
    clear_cnt();
    push(K_READ, 0, 0, 1'b0);
    push(K_START, 0, 0, 1'b0);
    push(K_DEL, 0, 0, 1'b0);
    start_conv(3'd3, 8'd2);
    send_beats(9);
    repeat (4) cyc1();
    chk("t6_no_read_9_beats", cnt[K_READ], 0);
    send_beats(1);
    wait_count("t6_read", K_READ, 1, 20);
    chk("t6_latency", read_cyc - beat_cyc, 2);
    wait_count("t6_start", K_START, 1, 20);
    send_beats(3);
    wait_count("t6_del", K_DEL, 1, 20);
    send_beats(9);
    repeat (3) cyc1();
    chk("t6_no_read_g1", cnt[K_READ], 1);
    chk("t6_group_idx", int'(group_idx), 1);
    sudo_reset = 1'b1;
    conv_en = 1'b0;
    cyc1();
    sudo_reset = 1'b0;
    chk("t6_sudo_outputs", int'({weight_read, pe_start, we_valid_del, tile_idx, group_idx, busy, done, err}), 0);
    chk("t6_queue_empty", exp_q.size(), 0);
    repeat (3) cyc1();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
